// File: rtl/pll_mgr_pkg.sv
// Shared types for the PLL supervisor: FSM state codes and counter sizing.
package pll_mgr_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_ENABLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } pll_state_e;

  // Width of the shared cycle counter: enough to hold the largest parameter.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    cnt_width = $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_ch_gate.sv
// One PLL output channel: orders enclk and ch_rst_n.
//   kill  - force enclk/ch_rst_n low at the next edge, no ordering
//   run   - follow req as a level
//   set   - sample req for the ENABLE slot of this channel
//   req   - channel request
//   enclk, ch_rst_n - registered outputs
module pll_ch_gate (
  input  logic clk,
  input  logic rst_n,
  input  logic kill,
  input  logic run,
  input  logic set,
  input  logic req,
  output logic enclk,
  output logic ch_rst_n
);

  logic want;
  logic d1_q, d1_d;
  logic d2_q, d2_d;
  logic enclk_q, enclk_d;
  logic ch_rst_n_q, ch_rst_n_d;

  // d1/d2 delay the wanted level; enclk is the OR and ch_rst_n the AND of the
  // three taps, so enclk leads ch_rst_n by 2 on the way up and lags it by 2 down.
  always_comb begin
    want       = run ? req : ((set && req) || d1_q);
    d1_d       = want;
    d2_d       = d1_q;
    enclk_d    = want || d1_q || d2_q;
    ch_rst_n_d = want && d1_q && d2_q;
    if (kill) begin
      d1_d       = 1'b0;
      d2_d       = 1'b0;
      enclk_d    = 1'b0;
      ch_rst_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q       <= 1'b0;
      d2_q       <= 1'b0;
      enclk_q    <= 1'b0;
      ch_rst_n_q <= 1'b0;
    end else begin
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      enclk_q    <= enclk_d;
      ch_rst_n_q <= ch_rst_n_d;
    end
  end

  assign enclk    = enclk_q;
  assign ch_rst_n = ch_rst_n_q;

endmodule

// File: rtl/pll_clk_manager.sv
// PLL supervisor: drives PLL reset, qualifies lock, staggers channel enables,
// retries on timeout/lock loss and latches a fault after MAX_RETRY failures.
//   clk, rst_n        - free-running reference clock, async active-low reset
//   pll_lock          - raw PLL lock (asynchronous)
//   sw_restart        - one-cycle restart pulse
//   ch_req            - per-channel enable request
//   pll_reset         - PLL reset, active-high
//   enclk, ch_rst_n   - per-channel clock enable and active-low reset
//   ready, fault      - sequence complete / retries exhausted
//   retry_cnt, state  - debug status
module pll_clk_manager
  import pll_mgr_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned PLL_RST_CYC  = 16,
  parameter int unsigned LOCK_FILT    = 64,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned STAGGER      = 8,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             pll_lock,
  input  logic                             sw_restart,
  input  logic [NUM_CH-1:0]                ch_req,
  output logic                             pll_reset,
  output logic [NUM_CH-1:0]                enclk,
  output logic [NUM_CH-1:0]                ch_rst_n,
  output logic                             ready,
  output logic                             fault,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
  output logic [2:0]                       state
);

  localparam int unsigned CNT_W  = cnt_width(PLL_RST_CYC, LOCK_FILT, LOCK_TIMEOUT, STAGGER);
  localparam int unsigned RTY_W  = $clog2(MAX_RETRY + 1);
  localparam int unsigned SLOT_W = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0]  FILT_LAST = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  STG_LAST  = CNT_W'(STAGGER - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);

  logic               lock_meta_q, lock_s_q;
  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [RTY_W-1:0]   retry_inc;
  logic               fail;
  logic               pll_reset_q, pll_reset_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               ch_kill, ch_run;
  logic [NUM_CH-1:0]  ch_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= ST_RESET_PLL;
      cnt_q       <= '0;
      tmo_q       <= '0;
      slot_q      <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      slot_q      <= slot_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    slot_d    = slot_q;
    retry_d   = retry_q;
    fail      = 1'b0;
    retry_inc = (retry_q == RTY_MAX) ? retry_q : retry_q + 1'b1;
    unique case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        // The cycle that first sees lock counts as the first filtered cycle.
        if (lock_s_q) begin
          if (LOCK_FILT <= 1) begin
            state_d = ST_ENABLE;
            cnt_d   = '0;
            slot_d  = '0;
          end else begin
            state_d = ST_FILTER;
            cnt_d   = CNT_W'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          fail = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_FILTER: begin
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = ST_ENABLE;
          cnt_d   = '0;
          slot_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ENABLE: begin
        if (!lock_s_q) begin
          fail = 1'b1;
        end else if (cnt_q == STG_LAST) begin
          cnt_d = '0;
          if (slot_q == SLOT_LAST) state_d = ST_RUN;
          else                     slot_d  = slot_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s_q) fail = 1'b1;
      end
      ST_FAULT: begin
      end
      default: state_d = ST_RESET_PLL;
    endcase
    if (fail) begin
      retry_d = retry_inc;
      state_d = (retry_inc == RTY_MAX) ? ST_FAULT : ST_RESET_PLL;
      cnt_d   = '0;
      tmo_d   = '0;
      slot_d  = '0;
    end
    if (sw_restart) begin
      state_d = ST_RESET_PLL;
      retry_d = '0;
      cnt_d   = '0;
      tmo_d   = '0;
      slot_d  = '0;
    end
  end

  // Outputs are decoded from the next state so every output flop changes on
  // the same edge as state_q.
  always_comb begin
    pll_reset_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
    ch_kill     = !((state_d == ST_ENABLE) || (state_d == ST_RUN));
    ch_run      = (state_q == ST_RUN);
    ch_set      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_set[i] = (state_q == ST_ENABLE) && (cnt_q == '0) && (slot_q == SLOT_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pll_ch_gate u_gate (
      .clk      (clk),
      .rst_n    (rst_n),
      .kill     (ch_kill),
      .run      (ch_run),
      .set      (ch_set[g]),
      .req      (ch_req[g]),
      .enclk    (enclk[g]),
      .ch_rst_n (ch_rst_n[g])
    );
  end

  assign pll_reset = pll_reset_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_clk_manager.sv
module tb_pll_clk_manager;

  localparam int unsigned NCH = 4;
  localparam int unsigned RND = 16 + 4096;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           pll_lock;
  logic           sw_restart;
  logic [NCH-1:0] ch_req;
  logic           pll_reset;
  logic [NCH-1:0] enclk;
  logic [NCH-1:0] ch_rst_n;
  logic           ready;
  logic           fault;
  logic [1:0]     retry_cnt;
  logic [2:0]     state;

  pll_clk_manager #(
    .NUM_CH       (NCH),
    .PLL_RST_CYC  (16),
    .LOCK_FILT    (64),
    .LOCK_TIMEOUT (4096),
    .STAGGER      (8),
    .MAX_RETRY    (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .sw_restart (sw_restart),
    .ch_req     (ch_req),
    .pll_reset  (pll_reset),
    .enclk      (enclk),
    .ch_rst_n   (ch_rst_n),
    .ready      (ready),
    .fault      (fault),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Signal ids: 0 pll_reset, 1 fault, 2 ready, 3..6 enclk[0..3], 7..10 ch_rst_n[0..3].
  // Event = {cycle, id*2+rise}; the queue is kept sorted so same-cycle events
  // come out in id order, matching the scan order in sample().
  localparam int PRST = 0, FLT = 1, RDY = 2, ENC = 3, CRN = 7;

  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [10:0] prev = 11'b000_0000_0001;
  logic [63:0] sb[$];

  function automatic string ev_str(input logic [63:0] e);
    int unsigned id;
    string nm;
    id = e[31:1];
    if (id == 0)       nm = "pll_reset";
    else if (id == 1)  nm = "fault";
    else if (id == 2)  nm = "ready";
    else if (id < 7)   nm = $sformatf("enclk%0d", id - 3);
    else               nm = $sformatf("ch_rst_n%0d", id - 7);
    return $sformatf("%s%s@%0d", nm, e[0] ? "+" : "-", e[63:32]);
  endfunction

  task automatic expect_ev(input int id, input bit rise, input int unsigned c);
    sb.push_back({c, 32'(id * 2 + (rise ? 1 : 0))});
    sb.sort();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic sample();
    logic [10:0] cur;
    logic [63:0] obs;
    logic [63:0] exp;
    cur = {ch_rst_n, enclk, ready, fault, pll_reset};
    for (int j = 0; j < 11; j++) begin
      if (cur[j] !== prev[j]) begin
        obs = {cyc, 32'(j * 2 + (cur[j] ? 1 : 0))};
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("FAIL event_unexpected observed=%s expected=none", ev_str(obs));
        end
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          assert (obs === exp) else begin
            miscompares++;
            $error("FAIL event observed=%s expected=%s", ev_str(obs), ev_str(exp));
          end
        end
      end
    end
    prev = cur;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic run_to(input int unsigned c);
    while (cyc < c) step();
  endtask

  task automatic drain(input string tag);
    if (sb.size() != 0) $display("pending event %s", ev_str(sb[0]));
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  int unsigned r, l, t, d, n, g, s, z;

  initial begin
    rst_n = 1'b1; pll_lock = 1'b0; sw_restart = 1'b0; ch_req = 4'hF;
    #1 rst_n = 1'b0;
    repeat (3) step();
    check("rst_pll_reset", pll_reset, 1);
    check("rst_enclk", enclk, 0);
    check("rst_ch_rst_n", ch_rst_n, 0);
    check("rst_ready", ready, 0);
    check("rst_fault", fault, 0);
    check("rst_retry", retry_cnt, 0);
    check("rst_state", state, 0);

    // Bring-up, all channels requested, lock 100 cycles after release.
    r = cyc;
    rst_n = 1'b1;
    expect_ev(PRST, 0, r + 16);
    run_to(r + 15);
    check("a_prst_last_hi", pll_reset, 1);
    run_to(r + 16);
    check("a_state_wait", state, 1);
    l = r + 100;
    run_to(l);
    pll_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_ev(ENC + i, 1, l + 67 + 8 * i);
      expect_ev(CRN + i, 1, l + 69 + 8 * i);
    end
    expect_ev(RDY, 1, l + 98);
    run_to(l + 66);
    check("a_state_enable", state, 3);
    run_to(l + 110);
    check("a_state_run", state, 4);
    check("a_enclk", enclk, 4'hF);
    drain("a_drain");

    // ch_req[3] falls then rises in RUN.
    t = cyc;
    ch_req = 4'b0111;
    expect_ev(CRN + 3, 0, t + 1);
    expect_ev(ENC + 3, 0, t + 3);
    run_to(t + 2);
    check("f_enclk_hold", enclk, 4'hF);
    check("f_crn_drop", ch_rst_n, 4'h7);
    run_to(t + 10);
    check("f_enclk", enclk, 4'h7);
    t = cyc;
    ch_req = 4'hF;
    expect_ev(ENC + 3, 1, t + 1);
    expect_ev(CRN + 3, 1, t + 3);
    run_to(t + 10);
    check("f_crn_back", ch_rst_n, 4'hF);
    drain("f_drain");

    // Lock lost in RUN, then re-sequence with ch_req=0101.
    d = cyc;
    pll_lock = 1'b0;
    expect_ev(PRST, 1, d + 3);
    expect_ev(RDY, 0, d + 3);
    for (int i = 0; i < 4; i++) begin
      expect_ev(ENC + i, 0, d + 3);
      expect_ev(CRN + i, 0, d + 3);
    end
    expect_ev(PRST, 0, d + 19);
    run_to(d + 2);
    check("e_state_still_run", state, 4);
    run_to(d + 3);
    check("e_state_reset", state, 0);
    check("e_retry1", retry_cnt, 1);
    check("e_enclk_off", enclk, 0);
    ch_req = 4'b0101;
    l = d + 40;
    run_to(l);
    pll_lock = 1'b1;
    expect_ev(ENC + 0, 1, l + 67);
    expect_ev(CRN + 0, 1, l + 69);
    expect_ev(ENC + 2, 1, l + 83);
    expect_ev(CRN + 2, 1, l + 85);
    expect_ev(RDY, 1, l + 98);
    run_to(l + 110);
    check("b_enclk", enclk, 4'h5);
    check("b_crn", ch_rst_n, 4'h5);
    check("b_retry", retry_cnt, 1);
    drain("b_drain");

    // sw_restart on the same edge as a lock fall, then a lock glitch in FILTER.
    n = cyc;
    pll_lock = 1'b0;
    expect_ev(PRST, 1, n + 3);
    expect_ev(RDY, 0, n + 3);
    expect_ev(ENC + 0, 0, n + 3);
    expect_ev(ENC + 2, 0, n + 3);
    expect_ev(CRN + 0, 0, n + 3);
    expect_ev(CRN + 2, 0, n + 3);
    expect_ev(PRST, 0, n + 19);
    run_to(n + 2);
    sw_restart = 1'b1;
    step();
    sw_restart = 1'b0;
    check("c_restart_not_retry", retry_cnt, 0);
    check("c_state_reset", state, 0);
    g = n + 30;
    run_to(g);
    pll_lock = 1'b1;
    run_to(g + 10);
    check("c_state_filter", state, 2);
    run_to(g + 20);
    pll_lock = 1'b0;
    run_to(g + 25);
    check("c_state_back_wait", state, 1);
    run_to(g + 30);
    pll_lock = 1'b1;
    expect_ev(ENC + 0, 1, g + 97);
    expect_ev(CRN + 0, 1, g + 99);
    expect_ev(ENC + 2, 1, g + 113);
    expect_ev(CRN + 2, 1, g + 115);
    expect_ev(RDY, 1, g + 128);
    run_to(g + 90);
    check("c_no_early_enclk", enclk, 0);
    run_to(g + 140);
    check("c_state_run", state, 4);
    drain("c_drain");

    // Lock never returns: three timeouts then FAULT, cleared by sw_restart.
    s = cyc;
    pll_lock = 1'b0;
    sw_restart = 1'b1;
    expect_ev(PRST, 1, s + 1);
    expect_ev(RDY, 0, s + 1);
    expect_ev(ENC + 0, 0, s + 1);
    expect_ev(ENC + 2, 0, s + 1);
    expect_ev(CRN + 0, 0, s + 1);
    expect_ev(CRN + 2, 0, s + 1);
    for (int k = 0; k < 3; k++) begin
      expect_ev(PRST, 0, s + 17 + k * RND);
      expect_ev(PRST, 1, s + 1 + (k + 1) * RND);
    end
    expect_ev(FLT, 1, s + 1 + 3 * RND);
    step();
    sw_restart = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      run_to(s + k * RND);
      check("d_retry_before", retry_cnt, 32'(k - 1));
      run_to(s + 1 + k * RND);
      check("d_retry_step", retry_cnt, 32'(k));
    end
    check("d_state_fault", state, 5);
    check("d_fault", fault, 1);
    check("d_pll_reset", pll_reset, 1);
    check("d_enclk", enclk, 0);
    drain("d_drain");
    z = cyc + 5;
    run_to(z);
    sw_restart = 1'b1;
    expect_ev(FLT, 0, z + 1);
    expect_ev(PRST, 0, z + 17);
    step();
    sw_restart = 1'b0;
    check("d_restart_state", state, 0);
    check("d_restart_retry", retry_cnt, 0);

    // Asynchronous reset in WAIT_LOCK takes effect without a clock edge.
    run_to(z + 30);
    rst_n = 1'b0;
    #1;
    check("g_async_state", state, 0);
    check("g_async_pll_reset", pll_reset, 1);
    expect_ev(PRST, 1, cyc + 1);
    step();
    step();
    drain("g_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_clk_manager.md
# pll_clk_manager

Parametrised PLL supervisor and clock-output sequencer that sits beside the vendor PLL wrapper in each project's clock tree. It drives the PLL reset, qualifies the lock signal, and releases the per-output clock enables and the per-channel resets in a fixed staggered order. It retries the PLL on lock timeout or lock loss and latches a fault after repeated failures. It runs on the free-running PLL input clock, so it stays alive whatever the PLL outputs are doing.

## Interface
- NUM_CH, 4: number of PLL output channels managed (1..7)
- PLL_RST_CYC, 16: cycles pll_reset is held high per attempt
- LOCK_FILT, 64: consecutive synchronised-lock cycles required before enabling
- LOCK_TIMEOUT, 4096: WAIT_LOCK cycles allowed before a retry
- STAGGER, 8: cycles between successive channel enable slots
- MAX_RETRY, 3: failed attempts before FAULT
- clk  in  1  PLL reference clock (free-running). One clock only; all logic is on clk.
- rst_n  in  1  asynchronous, active-low reset
- pll_lock  in  1  raw PLL LOCK (asynchronous), synchronised internally
- sw_restart  in  1  one-cycle pulse: restart the sequence from RESET_PLL and clear retries
- ch_req  in  NUM_CH  per-channel enable request (level)
- pll_reset  out  1  to PLL RESET, active-high
- enclk  out  NUM_CH  to PLL ENCLKn
- ch_rst_n  out  NUM_CH  per-channel active-low reset, resynchronised by consumers
- ready  out  1  sequence complete, PLL locked
- fault  out  1  MAX_RETRY exhausted
- retry_cnt  out  $clog2(MAX_RETRY+1)  failed attempts since the last restart
- state  out  3  FSM code, for debug

## Operation
- pll_lock passes through a 2-flop synchroniser to give lock_s. lock_s has 2 cycles of latency.
- FSM states and codes:
  - RESET_PLL (0): pll_reset=1. After PLL_RST_CYC cycles, go to WAIT_LOCK.
  - WAIT_LOCK (1): pll_reset=0. When lock_s=1, go to FILTER. If LOCK_TIMEOUT cycles pass without lock, retry.
  - FILTER (2): count consecutive lock_s=1 cycles. If lock_s=0, clear the count and go to WAIT_LOCK; the timeout counter is not reset. When the count reaches LOCK_FILT, go to ENABLE.
  - ENABLE (3): run slots i=0..NUM_CH-1, each STAGGER cycles long, starting at ENABLE entry.
    - In the first cycle of slot i, sample ch_req[i].
    - If it is 1, set enclk[i]; ch_rst_n[i] rises 2 cycles later.
    - Unrequested channels still consume their slot.
    - After NUM_CH*STAGGER cycles, go to RUN.
  - RUN (4): ready=1. Per channel:
    - ch_req rising: enclk high the next cycle, ch_rst_n high 2 cycles after that.
    - ch_req falling: ch_rst_n low the next cycle, enclk low 2 cycles after that.
  - FAULT (5): pll_reset=1, fault=1, all enclk=0 and all ch_rst_n=0. Left only by sw_restart or rst_n.
- Retry:
  - retry_cnt increments on a WAIT_LOCK timeout, or on lock_s falling while in ENABLE or RUN.
  - If the new value equals MAX_RETRY, go to FAULT; otherwise go to RESET_PLL.
  - retry_cnt saturates and is cleared only by sw_restart or rst_n.
- Lock loss in ENABLE or RUN: in the same cycle the FSM transitions, all ch_rst_n go to 0 and all enclk go to 0, with no stagger. ready drops with the transition.
- sw_restart in any state:
  - Go to RESET_PLL and clear retry_cnt, fault and all counters.
  - Outputs behave as on lock loss.
  - sw_restart takes priority over every other event in the same cycle.
- A sw_restart that coincides with a lock_s fall counts as a restart, not a retry.

## Timing
- Reset values: pll_reset=1, enclk=0, ch_rst_n=0, ready=0, fault=0, retry_cnt=0, state=0.
- All outputs are registered.
- Latency from raw lock to the first enclk: 2 (sync) + LOCK_FILT + 1 cycles.
- In RESET_PLL, pll_reset is high for exactly PLL_RST_CYC cycles.
- Counter widths: $clog2 of each parameter's maximum value + 1, with a single shared width for the cycle counter. No wraps are allowed; counters saturate or are cleared on state entry.
- rst_n assertion mid-sequence forces the reset values immediately, because the reset is asynchronous.

## Structure
- Shared package pll_mgr_pkg: the FSM state enum and its codes, and a function for the counter width.
- Sub-module pll_ch_gate, instantiated NUM_CH times. It owns the per-channel enclk/ch_rst_n ordering, the 2-cycle delay shift, and the immediate-kill input.
- The top level holds the synchroniser, the FSM, the cycle counter, the slot index and retry_cnt.

## Test plan
- Normal bring-up, defaults, ch_req=4'b1111, lock raised 100 cycles after rst_n rises:
  - pll_reset is high for cycles 0–15.
  - enclk[0] rises 2+64+1 cycles after lock.
  - enclk[1..3] follow at +8, +16 and +24 cycles.
  - Each ch_rst_n[i] rises 2 cycles after its enclk[i].
  - ready goes to 1 32 cycles after ENABLE entry.
- ch_req=4'b0101 -> only channels 0 and 2 are enabled, in slots 0 and 2. ready timing is unchanged.
- Lock glitch of 10 cycles during FILTER -> returns to WAIT_LOCK and the filter restarts. No enclk asserts until 64 clean cycles have passed.
- Lock never asserts:
  - 3 timeouts occur, retry_cnt steps 1→2→3.
  - FAULT: state=5, fault=1, pll_reset=1.
  - sw_restart -> state 0, retry_cnt=0.
- Lock dropped in RUN -> on the next transition all ch_rst_n=0 and enclk=0 in the same cycle, retry_cnt=1, state=0, then re-sequencing.
- In RUN, ch_req[3] goes 1→0:
  - ch_rst_n[3] falls in 1 cycle and enclk[3] falls 2 cycles later.
  - Channels 0–2 are unaffected.
